// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS control tokens, receiver FSM encoding and counter helpers
package tmds_pkg;
    localparam int CNT_W = 4;
    localparam logic [9:0] TOK_00 = 10'h354;
    localparam logic [9:0] TOK_01 = 10'h0AB;
    localparam logic [9:0] TOK_10 = 10'h154;
    localparam logic [9:0] TOK_11 = 10'h2AB;
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    // {hit, cd}: hit=1 when the word is one of the four control tokens
    function automatic logic [2:0] tok_lookup(input logic [9:0] w);
        return w == TOK_00 ? 3'b100 :
               w == TOK_01 ? 3'b101 :
               w == TOK_10 ? 3'b110 :
               w == TOK_11 ? 3'b111 : 3'b000;
    endfunction
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return &c ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/tmds_word_decode.sv
// tmds_word_decode: combinational decode of one 10-bit TMDS word into VD, CD and token flag
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] w,
    output logic [7:0] VD,
    output logic [1:0] CD,
    output logic       is_tok
);
    logic [7:0] q;
    logic [6:0] x;
    assign q = w[9] ? ~w[7:0] : w[7:0];
    assign x = q[7:1] ^ q[6:0];
    assign VD = {w[8] ? x : ~x, q[0]};
    assign {is_tok, CD} = tok_lookup(w);
endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: serial TMDS channel receiver with token-based word alignment and decode
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT   = 8,
    parameter int MISALIGN_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sdata,
    output logic [7:0] VD,
    output logic [1:0] CD,
    output logic       VDE,
    output logic       word_valid,
    output logic       locked
);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0] MIS_LAST  = CNT_W'(MISALIGN_MAX - 1);
    logic [9:0] sr, w;
    logic [1:0] state;
    logic [CNT_W-1:0] bit_cnt, match_cnt, mis_cnt;
    logic last_tok, is_tok, bnd;
    logic [7:0] dvd;
    logic [1:0] dcd;
    assign w = {sdata, sr[9:1]};
    assign bnd = bit_cnt == 4'd9;
    tmds_word_decode u_dec (.w(w), .VD(dvd), .CD(dcd), .is_tok(is_tok));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
            bit_cnt <= '0;
            match_cnt <= '0;
            mis_cnt <= '0;
            sr <= '0;
            last_tok <= 1'b0;
            VD <= '0;
            CD <= '0;
            VDE <= 1'b0;
            word_valid <= 1'b0;
            locked <= 1'b0;
        end else begin
            sr <= w;
            if (state != SEARCH) bit_cnt <= bnd ? '0 : bit_cnt + 1'b1;
            // remembers whether the most recent boundary word was a token
            if (bnd || state == SEARCH) last_tok <= is_tok;
            case (state)
                SEARCH: if (is_tok) begin
                    bit_cnt <= '0;
                    match_cnt <= 4'd1;
                    state <= VERIFY;
                end
                VERIFY: if (bnd) begin
                    if (!is_tok) begin
                        state <= SEARCH;
                        match_cnt <= '0;
                    end else begin
                        match_cnt <= sat_inc(match_cnt);
                        if (match_cnt == LOCK_LAST) begin
                            state <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    word_valid <= bnd;
                    if (bnd) begin
                        VDE <= !is_tok;
                        VD <= is_tok ? '0 : dvd;
                        if (is_tok) begin
                            CD <= dcd;
                            mis_cnt <= '0;
                        end
                    end else if (is_tok && !last_tok) begin
                        mis_cnt <= sat_inc(mis_cnt);
                        // a token seen off-phase too often: drop lock and rescan
                        if (mis_cnt == MIS_LAST) begin
                            state <= SEARCH;
                            locked <= 1'b0;
                            mis_cnt <= '0;
                            VDE <= 1'b0;
                            VD <= '0;
                            CD <= '0;
                        end
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed serial-word bench for tmds_decoder
module tb_tmds_decoder;
    logic clk, rst, sdata;
    logic [7:0] VD;
    logic [1:0] CD;
    logic VDE, word_valid, locked;
    int errors = 0;
    int checks = 0;
    localparam logic [9:0] T354 = 10'h354, T0AB = 10'h0AB, T154 = 10'h154, T2AB = 10'h2AB;

    tmds_decoder #(.LOCK_COUNT(8), .MISALIGN_MAX(4)) dut (
        .clk(clk), .rst(rst), .sdata(sdata), .VD(VD), .CD(CD),
        .VDE(VDE), .word_valid(word_valid), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sdata = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] wd);
        for (int i = 0; i < 10; i++) send_bit(wd[i]);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        send_bit(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [9:0] wd;
        rst = 1'b1;
        sdata = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", {7'd0, locked}, 8'd0);
        chk("rst_vde", {7'd0, VDE}, 8'd0);
        chk("rst_vd", VD, 8'h00);
        chk("rst_cd", {6'd0, CD}, 8'd0);
        chk("rst_wv", {7'd0, word_valid}, 8'd0);
        rst = 1'b0;
        // 1: junk then 8 aligned tokens
        repeat (3) send_bit(1'b1);
        for (int t = 1; t <= 8; t++) begin
            send_word(T354);
            if (t < 8) begin
                chk("t1_prelock", {7'd0, locked}, 8'd0);
                chk("t1_no_wv", {7'd0, word_valid}, 8'd0);
            end
        end
        chk("t1_lock", {7'd0, locked}, 8'd1);
        send_word(T354);
        chk("t1_wv", {7'd0, word_valid}, 8'd1);
        chk("t1_vde", {7'd0, VDE}, 8'd0);
        chk("t1_cd", {6'd0, CD}, 8'd0);
        // 2: data words then a token
        send_word(10'h100);
        chk("t2_vd100", VD, 8'h00);
        chk("t2_vde100", {7'd0, VDE}, 8'd1);
        chk("t2_wv100", {7'd0, word_valid}, 8'd1);
        wd = 10'h0FF;
        send_bit(wd[0]);
        chk("t2_wv_pulse", {7'd0, word_valid}, 8'd0);
        for (int i = 1; i < 10; i++) send_bit(wd[i]);
        chk("t2_vd0ff", VD, 8'hFF);
        chk("t2_wv0ff", {7'd0, word_valid}, 8'd1);
        send_word(10'h200);
        chk("t2_vd200", VD, 8'hFF);
        chk("t2_vde200", {7'd0, VDE}, 8'd1);
        send_word(T2AB);
        chk("t2_tok_vde", {7'd0, VDE}, 8'd0);
        chk("t2_tok_cd", {6'd0, CD}, 8'd3);
        chk("t2_tok_vd", VD, 8'h00);
        // 3: all four tokens
        send_word(T354);
        chk("t3_cd00", {6'd0, CD}, 8'd0);
        send_word(T0AB);
        chk("t3_cd01", {6'd0, CD}, 8'd1);
        send_word(T154);
        chk("t3_cd10", {6'd0, CD}, 8'd2);
        send_word(T2AB);
        chk("t3_cd11", {6'd0, CD}, 8'd3);
        chk("t3_wv", {7'd0, word_valid}, 8'd1);
        chk("t3_locked", {7'd0, locked}, 8'd1);
        // 4: one extra bit in a 0x154 run shifts the phase by one
        send_word(T154);
        send_word(T154);
        chk("t4_cd", {6'd0, CD}, 8'd2);
        send_bit(1'b0);
        wd = T154;
        for (int i = 0; i < 10; i++) begin
            send_bit(wd[i]);
            if (i == 8) begin
                chk("t4_rot_vde", {7'd0, VDE}, 8'd1);
                chk("t4_rot_vd", VD, 8'h07);
            end
        end
        send_word(T154);
        send_word(T154);
        chk("t4_still_locked", {7'd0, locked}, 8'd1);
        send_word(T154);
        chk("t4_unlock", {7'd0, locked}, 8'd0);
        chk("t4_unlock_vde", {7'd0, VDE}, 8'd0);
        for (int t = 1; t <= 8; t++) begin
            send_word(T154);
            if (t == 7) chk("t4_prerelock", {7'd0, locked}, 8'd0);
        end
        chk("t4_relock", {7'd0, locked}, 8'd1);
        // 5: data word during verify aborts the lock attempt
        pulse_rst();
        repeat (3) send_word(T354);
        chk("t5_verify", {7'd0, locked}, 8'd0);
        send_word(10'h100);
        chk("t5_abort", {7'd0, locked}, 8'd0);
        for (int t = 1; t <= 8; t++) begin
            send_word(T354);
            if (t == 7) chk("t5_prelock", {7'd0, locked}, 8'd0);
        end
        chk("t5_lock", {7'd0, locked}, 8'd1);
        // 6: reset mid data word while locked
        send_word(T154);
        send_word(10'h100);
        chk("t6_vde", {7'd0, VDE}, 8'd1);
        chk("t6_cd_held", {6'd0, CD}, 8'd2);
        wd = 10'h0FF;
        for (int i = 0; i < 5; i++) send_bit(wd[i]);
        rst = 1'b1;
        send_bit(wd[5]);
        rst = 1'b0;
        chk("t6_locked", {7'd0, locked}, 8'd0);
        chk("t6_vd", VD, 8'h00);
        chk("t6_cd", {6'd0, CD}, 8'd0);
        chk("t6_vde0", {7'd0, VDE}, 8'd0);
        chk("t6_wv", {7'd0, word_valid}, 8'd0);
        for (int i = 6; i < 10; i++) send_bit(wd[i]);
        for (int t = 1; t <= 8; t++) begin
            send_word(T354);
            if (t == 7) chk("t6_prelock", {7'd0, locked}, 8'd0);
        end
        chk("t6_relock", {7'd0, locked}, 8'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
